// File: rtl/seq_differencer_pkg.sv
// Shared types for the running-sum differencer.
// Included first so the interface and datapath agree on defaults.
package seq_differencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seqd_state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/seq_differencer_if.sv
// Stream bundle for the differencer.
// Carries the sum input side, the difference output side and the error flag.
interface seq_differencer_if
    import seq_differencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_first;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_last;
    logic             frame_err;

    modport master (
        output in_valid, in_sum, in_first, out_ready,
        input  in_ready, out_valid, out_diff, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_sum, in_first, out_ready,
        output in_ready, out_valid, out_diff, out_last, frame_err
    );

endinterface

// File: rtl/seq_differencer_sub.sv
// Modular subtractor, companion of the accumulator's adder.
// Wraps mod 2^WIDTH so it exactly undoes adder overflow.
module sub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o
);

    assign diff_o = a_i - b_i;

endmodule

// File: rtl/seq_differencer.sv
// Recovers A[n] = S[n] - S[n-1] from a framed running-sum stream.
// One registered output stage, one sample per clock.
module seq_differencer
    import seq_differencer_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    seq_differencer_if.slave   bus
);

    seqd_state_t      state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] base;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             vld_q;
    logic             last_q;
    logic             err_q;
    logic             last_d;
    logic             start;
    logic             accept;
    logic             take;

    assign bus.in_ready = reset && (state_q != DRAIN)
                        && (!vld_q || bus.out_ready);

    assign accept = bus.in_valid && bus.in_ready;
    assign take   = vld_q && bus.out_ready;

    // IDLE always begins a frame, even without in_first
    assign start  = (state_q == IDLE) || bus.in_first;
    assign base   = start ? '0 : prev_q;
    assign cnt_d  = start ? 8'd1 : cnt_q + 8'd1;
    assign last_d = (cnt_d == 8'(FRAME_LEN));

    sub_nbit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i    (bus.in_sum),
        .b_i    (base),
        .diff_o (diff_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            diff_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (take)
                vld_q <= 1'b0;
            if (accept) begin
                vld_q   <= 1'b1;
                diff_q  <= diff_d;
                last_q  <= last_d;
                prev_q  <= bus.in_sum;
                cnt_q   <= cnt_d;
                state_q <= last_d ? DRAIN : RUN;
                if (state_q == RUN && bus.in_first)
                    err_q <= 1'b1;
            end else if (state_q == DRAIN && take && last_q) begin
                state_q <= IDLE;
                prev_q  <= '0;
                cnt_q   <= '0;
            end
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_diff  = diff_q;
    assign bus.out_last  = last_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_seq_differencer.sv
// Self-checking bench for seq_differencer (WIDTH=8, FRAME_LEN=4).
// Directed scenarios plus a random stream against an accumulator model.
module tb_seq_differencer;

    localparam int W  = 8;
    localparam int FL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got_d[$];
    logic         got_l[$];
    bit           acc;

    seq_differencer_if #(.WIDTH(W)) bus ();

    seq_differencer #(
        .WIDTH     (W),
        .FRAME_LEN (FL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One clock: note handshakes just before the edge, then settle after it
    task automatic step();
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_diff);
            got_l.push_back(bus.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] s, input logic f,
                       output int waits);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        bus.in_first = f;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc) break;
            waits++;
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic flush();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b0;
        bus.in_sum    = 8'h55;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({bus.out_valid, bus.out_last, bus.frame_err, bus.in_ready}
            !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got v%b l%b e%b r%b want 0000",
                     bus.out_valid, bus.out_last, bus.frame_err,
                     bus.in_ready);
        end
        checks++;
        if (bus.out_diff !== 8'h00) begin
            errors++;
            $display("FAIL reset_diff got %h want 00", bus.out_diff);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_frame();
        logic [W-1:0] ed[5];
        logic         el[5];
        int           w;
        int           w4;
        ed = '{8'h03, 8'h05, 8'h00, 8'h02, 8'h11};
        el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.out_ready = 1'b1;
        w = 0;
        put(8'h03, 1'b1, w4); w += w4;
        put(8'h08, 1'b0, w4); w += w4;
        put(8'h08, 1'b0, w4); w += w4;
        put(8'h0A, 1'b0, w4); w += w4;
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL frame_stalls got %0d want 0", w);
        end
        put(8'h11, 1'b1, w4);
        checks++;
        if (w4 !== 1) begin
            errors++;
            $display("FAIL frame_gap got %0d want 1", w4);
        end
        flush();
        checks++;
        if (got_d.size() !== 5) begin
            errors++;
            $display("FAIL frame_count got %0d want 5", got_d.size());
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                errors++;
                $display("FAIL frame_out[%0d] got %h/%b want %h/%b",
                         i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_idle got %b want 0", bus.frame_err);
        end
    endtask

    task automatic test_wrap();
        int w;
        do_reset();
        bus.out_ready = 1'b1;
        put(8'hFE, 1'b1, w);
        put(8'h02, 1'b0, w);
        flush();
        checks++;
        if (got_d.size() !== 2 || got_d[0] !== 8'hFE
            || got_d[1] !== 8'h04) begin
            errors++;
            $display("FAIL wrap got %p want FE,04", got_d);
        end
    endtask

    task automatic test_backpressure();
        int w;
        do_reset();
        bus.out_ready = 1'b1;
        put(8'h10, 1'b1, w);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 8'h15;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
                || bus.out_diff !== 8'h10) begin
                errors++;
                $display("FAIL bp_hold[%0d] got r%b v%b %h want r0 v1 10",
                         k, bus.in_ready, bus.out_valid, bus.out_diff);
            end
            step();
        end
        bus.out_ready = 1'b1;
        put(8'h15, 1'b0, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL bp_release got %0d waits want 0", w);
        end
        put(8'h17, 1'b0, w);
        flush();
        checks++;
        if (got_d.size() !== 3 || got_d[0] !== 8'h10
            || got_d[1] !== 8'h05 || got_d[2] !== 8'h02) begin
            errors++;
            $display("FAIL bp_stream got %p want 10,05,02", got_d);
        end
    endtask

    task automatic test_restart();
        int w;
        do_reset();
        bus.out_ready = 1'b1;
        put(8'h05, 1'b1, w);
        put(8'h07, 1'b0, w);
        put(8'h10, 1'b1, w);
        flush();
        checks++;
        if (got_d.size() !== 3 || got_d[0] !== 8'h05
            || got_d[1] !== 8'h02 || got_d[2] !== 8'h10) begin
            errors++;
            $display("FAIL restart_stream got %p want 05,02,10", got_d);
        end
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL restart_sticky got %b want 1", bus.frame_err);
        end
        do_reset();
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got %b want 0", bus.frame_err);
        end
    endtask

    task automatic test_midreset();
        int w;
        do_reset();
        bus.out_ready = 1'b1;
        put(8'h05, 1'b1, w);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got %b want 1", bus.out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready got %b want 0", bus.in_ready);
        end
        step();
        reset = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_diff !== 8'h00) begin
            errors++;
            $display("FAIL midrst_out got v%b %h want v0 00",
                     bus.out_valid, bus.out_diff);
        end
        got_d.delete();
        got_l.delete();
        bus.out_ready = 1'b1;
        put(8'h09, 1'b0, w);
        flush();
        checks++;
        if (got_d.size() !== 1 || got_d[0] !== 8'h09) begin
            errors++;
            $display("FAIL midrst_next got %p want 09", got_d);
        end
    endtask

    // Accumulator model: A[n] random, S = A + S per frame; expect A back
    task automatic test_random();
        logic [W-1:0] bs[$];
        logic         bf[$];
        logic [W-1:0] ea[$];
        logic         el[$];
        logic [W-1:0] a;
        logic [W-1:0] s;
        int           n;
        int           bi;
        int           bad;
        do_reset();
        for (int fr = 0; fr < 40; fr++) begin
            s = '0;
            for (int i = 0; i < FL; i++) begin
                a = W'($urandom);
                s = s + a;
                bs.push_back(s);
                bf.push_back(i == 0 ? ($urandom_range(0, 3) != 0) : 1'b0);
                ea.push_back(a);
                el.push_back(i == FL - 1);
            end
        end
        n  = bs.size();
        bi = 0;
        for (int cyc = 0; cyc < 4000 && (bi < n || got_d.size() < n);
             cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = (bi < n) && ($urandom_range(0, 2) != 0);
            bus.in_sum    = (bi < n) ? bs[bi] : '0;
            bus.in_first  = (bi < n) ? bf[bi] : 1'b0;
            step();
            if (acc) bi++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got_d.size() !== n) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", got_d.size(), n);
        end
        bad = 0;
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            if (got_d[i] !== ea[i] || got_l[i] !== el[i]) begin
                if (bad < 5)
                    $display("FAIL rand_out[%0d] got %h/%b want %h/%b",
                             i, got_d[i], got_l[i], ea[i], el[i]);
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_total got %0d bad want 0", bad);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_err got %b want 0", bus.frame_err);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_frame();
        test_wrap();
        test_backpressure();
        test_restart();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
